// File: rtl/system_controller_pkg.sv
// Shared command codes and FSM encoding for the UART register-access controller.
// Imported by the controller RTL and by its testbench.
package system_controller_pkg;

  localparam logic [7:0] CMD_WRITE = 8'hAA;
  localparam logic [7:0] CMD_READ  = 8'hBB;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WRITE   = 3'd3,
    RD_ADDR = 3'd4,
    READ    = 3'd5,
    RD_WAIT = 3'd6,
    SEND    = 3'd7
  } state_t;

  function automatic logic is_strobe_state(state_t s);
    return (s == WRITE) || (s == READ);
  endfunction

endpackage

// File: rtl/system_controller.sv
// UART byte-command controller: 0xAA addr data -> register write,
// 0xBB addr -> register read, result sent back through the UART transmitter.
// Ports: clk, reset_n (sync, active-low); rx_data/rx_data_valid from UART RX;
// address/write_en/read_en/write_data/read_data/read_data_valid to the
// register file; tx_data/tx_data_valid/tx_busy to UART TX; cmd_error pulse.
module system_controller
  import system_controller_pkg::*;
#(
  parameter int DATA_WIDTH          = 8,
  parameter int REGISTER_FILE_DEPTH = 16,
  parameter int READ_TIMEOUT        = 4,
  localparam int ADDR_WIDTH         = $clog2(REGISTER_FILE_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_data_valid,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  write_en,
  output logic                  read_en,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  read_data_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_data_valid,
  input  logic                  tx_busy,
  output logic                  cmd_error
);

  localparam int CNT_WIDTH = $clog2(READ_TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(READ_TIMEOUT - 1);

  state_t                state_q;
  state_t                state_d;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic [ADDR_WIDTH-1:0] address_d;
  logic [DATA_WIDTH-1:0] write_data_d;
  logic [DATA_WIDTH-1:0] tx_data_d;
  logic                  cmd_error_d;
  logic                  is_wr_cmd;
  logic                  is_rd_cmd;

  assign is_wr_cmd = (rx_data == DATA_WIDTH'(CMD_WRITE));
  assign is_rd_cmd = (rx_data == DATA_WIDTH'(CMD_READ));

  // The response window is READ_TIMEOUT cycles long and starts with
  // the read_en cycle, since read data may already return there.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    address_d    = address;
    write_data_d = write_data;
    tx_data_d    = tx_data;
    cmd_error_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_data_valid) begin
          unique case (1'b1)
            is_wr_cmd: state_d = WR_ADDR;
            is_rd_cmd: state_d = RD_ADDR;
            default:   cmd_error_d = 1'b1;
          endcase
        end
      end
      WR_ADDR: begin
        if (rx_data_valid) begin
          address_d = rx_data[ADDR_WIDTH-1:0];
          state_d   = WR_DATA;
        end
      end
      WR_DATA: begin
        if (rx_data_valid) begin
          write_data_d = rx_data;
          state_d      = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      RD_ADDR: begin
        if (rx_data_valid) begin
          address_d = rx_data[ADDR_WIDTH-1:0];
          cnt_d     = '0;
          state_d   = READ;
        end
      end
      READ: begin
        if (read_data_valid) begin
          tx_data_d = read_data;
          state_d   = SEND;
        end else if (READ_TIMEOUT <= 1) begin
          cmd_error_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d   = CNT_WIDTH'(1);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (read_data_valid) begin
          tx_data_d = read_data;
          state_d   = SEND;
        end else if (cnt_q >= CNT_LAST) begin
          cmd_error_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      SEND: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so each is high exactly
  // while the FSM sits in its one-cycle WRITE or READ state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      address    <= '0;
      write_data <= '0;
      tx_data    <= '0;
      write_en   <= 1'b0;
      read_en    <= 1'b0;
      cmd_error  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      address    <= address_d;
      write_data <= write_data_d;
      tx_data    <= tx_data_d;
      write_en   <= is_strobe_state(state_d) && (state_d == WRITE);
      read_en    <= is_strobe_state(state_d) && (state_d == READ);
      cmd_error  <= cmd_error_d;
    end
  end

  // Same-cycle handshake with the transmitter: fires the first cycle
  // SEND sees tx_busy low, and the FSM leaves SEND on that edge.
  assign tx_data_valid = (state_q == SEND) && !tx_busy;

endmodule

// File: tb/tb_system_controller.sv
// Scoreboard testbench for system_controller: directed UART command bytes,
// register-file model, expected strobes queued and checked by a monitor.
module tb_system_controller;
  import system_controller_pkg::*;

  typedef enum int {EV_WR, EV_RD, EV_TX, EV_ERR} ev_t;

  typedef struct {
    ev_t        kind;
    logic [3:0] a;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic [3:0] address;
  logic       write_en;
  logic       read_en;
  logic [7:0] write_data;
  logic [7:0] read_data;
  logic       read_data_valid;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_busy;
  logic       cmd_error;

  logic [7:0] rf [16];
  logic       rf_respond;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  exp_t       q[$];

  system_controller dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rx_data         (rx_data),
    .rx_data_valid   (rx_data_valid),
    .address         (address),
    .write_en        (write_en),
    .read_en         (read_en),
    .write_data      (write_data),
    .read_data       (read_data),
    .read_data_valid (read_data_valid),
    .tx_data         (tx_data),
    .tx_data_valid   (tx_data_valid),
    .tx_busy         (tx_busy),
    .cmd_error       (cmd_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: responds one cycle after read_en when enabled.
  always @(posedge clk) begin
    if (write_en) rf[address] <= write_data;
    read_data       <= rf[address];
    read_data_valid <= read_en && rf_respond;
  end

  task automatic push(ev_t k, logic [3:0] a, logic [7:0] d, int c);
    exp_t e;
    e.kind = k;
    e.a    = a;
    e.d    = d;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic check_ev(ev_t k, logic [3:0] a, logic [7:0] d);
    exp_t e;
    n_checks++;
    if (q.size() == 0) begin
      $display("FAIL unexpected_%s: got a=%h d=%h cyc=%0d, required none",
               k.name(), a, d, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind == k && e.a == a && e.d == d && e.cyc == cyc) begin
        n_pass++;
      end else begin
        $display("FAIL event_%s: got %s a=%h d=%h cyc=%0d, required %s a=%h d=%h cyc=%0d",
                 e.kind.name(), k.name(), a, d, cyc,
                 e.kind.name(), e.a, e.d, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (write_en)      check_ev(EV_WR, address, write_data);
      if (read_en)       check_ev(EV_RD, address, 8'h00);
      if (tx_data_valid) check_ev(EV_TX, 4'h0, tx_data);
      if (cmd_error)     check_ev(EV_ERR, 4'h0, 8'h00);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int s);
    rx_data       = b;
    rx_data_valid = 1'b1;
    s             = cyc + 1;
    tick();
    rx_data_valid = 1'b0;
  endtask

  task automatic check_reset_state(string name);
    logic [32:0] got;
    got = {address, write_en, read_en, write_data, tx_data,
           tx_data_valid, cmd_error};
    n_checks++;
    if (got == '0) n_pass++;
    else $display("FAIL %s: got outputs=%h, required 0", name, got);
  endtask

  task automatic check_hold(string name, logic [3:0] a, logic [7:0] d);
    n_checks++;
    if (address == a && write_data == d) n_pass++;
    else $display("FAIL %s: got a=%h d=%h, required a=%h d=%h",
                  name, address, write_data, a, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    reset_n       = 1'b0;
    rx_data       = 8'h00;
    rx_data_valid = 1'b0;
    tx_busy       = 1'b0;
    rf_respond    = 1'b1;
    repeat (3) tick();
    check_reset_state("reset_init");
    reset_n = 1'b1;
    tick();

    // Write: AA 0E F4
    send_byte(CMD_WRITE, s);
    send_byte(8'h0E, s);
    send_byte(8'hF4, s);
    push(EV_WR, 4'hE, 8'hF4, s);
    repeat (3) tick();
    check_hold("hold_after_write", 4'hE, 8'hF4);

    // Read: BB 0E, immediate transmitter
    send_byte(CMD_READ, s);
    send_byte(8'h0E, s);
    push(EV_RD, 4'hE, 8'h00, s);
    push(EV_TX, 4'h0, 8'hF4, s + 2);
    repeat (5) tick();

    // Read with busy transmitter; a byte arriving in SEND is dropped
    tx_busy = 1'b1;
    send_byte(CMD_READ, s);
    send_byte(8'h0E, s);
    push(EV_RD, 4'hE, 8'h00, s);
    repeat (3) tick();
    send_byte(CMD_WRITE, s);
    repeat (6) tick();
    tx_busy = 1'b0;
    push(EV_TX, 4'h0, 8'hF4, cyc);
    tick();
    send_byte(8'h55, s);
    push(EV_ERR, 4'h0, 8'h00, s);
    repeat (3) tick();

    // Unknown command from a clean IDLE
    send_byte(8'h55, s);
    push(EV_ERR, 4'h0, 8'h00, s);
    repeat (3) tick();

    // Reset mid-command, then a full write
    send_byte(CMD_WRITE, s);
    send_byte(8'h3E, s);
    reset_n = 1'b0;
    tick();
    check_reset_state("reset_mid_cmd");
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    send_byte(CMD_WRITE, s);
    send_byte(8'h3E, s);
    send_byte(8'h11, s);
    push(EV_WR, 4'hE, 8'h11, s);
    repeat (3) tick();

    // Read timeout, then the next command is accepted
    rf_respond = 1'b0;
    send_byte(CMD_READ, s);
    send_byte(8'h05, s);
    push(EV_RD, 4'h5, 8'h00, s);
    push(EV_ERR, 4'h0, 8'h00, s + 4);
    repeat (8) tick();
    rf_respond = 1'b1;
    send_byte(CMD_READ, s);
    send_byte(8'h0E, s);
    push(EV_RD, 4'hE, 8'h00, s);
    push(EV_TX, 4'h0, 8'h11, s + 2);

    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    repeat (4) tick();
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, required 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/system_controller.md
SYSTEM_CONTROLLER -- requirements
Module: system_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of UART bytes and register data.
REQ-002 Parameter REGISTER_FILE_DEPTH, default 16, SHALL set the address range; ADDR_WIDTH = $clog2(REGISTER_FILE_DEPTH).
REQ-003 Parameter READ_TIMEOUT, default 4, SHALL set the maximum cycles to wait for read_data_valid.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 rx_data  input  DATA_WIDTH  byte from the UART receiver.
REQ-007 rx_data_valid  input  1  one-cycle pulse qualifying rx_data.
REQ-008 address  output  ADDR_WIDTH  register-file address.
REQ-009 write_en  output  1  register-file write strobe.
REQ-010 read_en  output  1  register-file read strobe.
REQ-011 write_data  output  DATA_WIDTH  register-file write data.
REQ-012 read_data  input  DATA_WIDTH  register-file read data.
REQ-013 read_data_valid  input  1  qualifies read_data.
REQ-014 tx_data  output  DATA_WIDTH  byte to the UART transmitter.
REQ-015 tx_data_valid  output  1  one-cycle pulse qualifying tx_data.
REQ-016 tx_busy  input  1  transmitter is busy and cannot accept a byte.
REQ-017 cmd_error  output  1  one-cycle pulse on an unknown command or a read timeout.

Function
REQ-018 The FSM states SHALL be IDLE, WR_ADDR, WR_DATA, WRITE, RD_ADDR, READ, RD_WAIT and SEND.
REQ-019 In IDLE, a received byte 0xAA SHALL go to WR_ADDR, 0xBB SHALL go to RD_ADDR, and any other byte SHALL pulse cmd_error for the next cycle and stay in IDLE.
REQ-020 WR_ADDR and RD_ADDR SHALL, on rx_data_valid, latch rx_data[ADDR_WIDTH-1:0] into address and ignore the upper bits; next states are WR_DATA and READ respectively.
REQ-021 WR_DATA SHALL, on rx_data_valid, latch rx_data into write_data and go to WRITE.
REQ-022 WRITE SHALL assert write_en for exactly one cycle and then return to IDLE.
REQ-023 Write latency: write_en SHALL be high in the cycle after the data byte's rx_data_valid cycle.
REQ-024 READ SHALL assert read_en for exactly one cycle, in the cycle after the address byte's rx_data_valid, and then go to RD_WAIT.
REQ-025 RD_WAIT SHALL capture read_data into tx_data when read_data_valid is high, including in the cycle read_en is high, and then go to SEND.
REQ-026 If RD_WAIT lasts READ_TIMEOUT cycles without read_data_valid, the block SHALL pulse cmd_error and return to IDLE.
REQ-027 SEND SHALL wait while tx_busy=1; in the first cycle with tx_busy=0 it SHALL pulse tx_data_valid with tx_data stable and return to IDLE.
REQ-028 rx_data_valid SHALL be ignored in WRITE, READ, RD_WAIT and SEND, with the byte dropped.
REQ-029 write_en, read_en and tx_data_valid SHALL be mutually exclusive and never high for more than one consecutive cycle.
REQ-030 address, write_data and tx_data SHALL hold their last latched values between transactions.

Reset
REQ-031 While reset_n=0 at a clock edge, the state SHALL become IDLE and every output SHALL become 0, including address, write_data, tx_data, all strobes and cmd_error.
REQ-032 A reset in mid-command SHALL discard the partial command, with no write_en, read_en or tx_data_valid issued afterwards for it.

Structure
REQ-033 The command codes (0xAA, 0xBB) and the state encoding SHALL reside in a shared package also used by the bench.
REQ-034 The block SHALL be a single module with no sub-module; the timeout counter is internal.

Verification
REQ-035 Send bytes 0xAA, 0x0E, 0xF4 -> write_en high for one cycle with address=0xE and write_data=0xF4, in the cycle after the third byte.
REQ-036 Send 0xBB, 0x0E with a register-file model returning 0xF4 one cycle after read_en, tx_busy=0 -> read_en pulses once, then tx_data_valid pulses once with tx_data=0xF4.
REQ-037 Same read with tx_busy held high for 10 cycles -> tx_data_valid is withheld and pulses in the first cycle tx_busy=0.
REQ-038 Send 0x55 -> cmd_error pulses once, and no write_en or read_en occurs.
REQ-039 Send 0xAA, 0x3E, then reset_n=0 before the data byte -> no write_en; after reset, 0xAA, 0x3E, 0x11 writes address=0xE with data 0x11.
REQ-040 Send 0xBB, 0x05 with read_data_valid never asserted -> cmd_error pulses 4 cycles after read_en, no tx_data_valid occurs, and the next command is accepted.
